main_ctrl_fsm: RTL and testbench

//  Multicycle ARM main control FSM; sits directly upstream of condlogic.

---
 rtl/main_ctrl_fsm_if.sv | 31 +++
 rtl/main_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_main_ctrl_fsm.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/main_ctrl_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath/condlogic.
// The FSM side uses the master modport; the datapath/condlogic side uses slave.
interface main_ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;

  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       Undef;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, Undef
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, Undef
  );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle ARM main control FSM, upstream of condlogic.
// Walks each instruction through fetch/decode/execute/writeback and stalls
// on MemReady in FETCH, MEMRD and MEMWR.
// Optional feature macro: MAIN_FSM_INSTR_CNT_EN adds a retired-instruction
// counter on output InstrCount[CNT_W-1:0].
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC; PC+4 written when memory is ready
// DECODE   | read registers, classify opcode; flag undefined opcodes
// MEMADR   | ALU forms load/store address from base + immediate
// MEMRD    | load data read, waits for MemReady
// MEMWB    | load data written back to the register file
// MEMWR    | store write strobe held until MemReady
// EXECUTER | data-processing op with register operand B
// EXECUTEI | data-processing op with immediate operand B
// ALUWB    | ALU result written back to the register file
// BRANCH   | branch target computed and handed to condlogic
module main_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  main_ctrl_fsm_if.master   bus
`ifdef MAIN_FSM_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0]  InstrCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode. Everything stays 0 while reset is low, so
  // an aborted instruction never leaks a RegW/MemW/Branch strobe.
  always_comb begin
    state_d       = S_FETCH;
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.Undef     = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          bus.ALUSrcA   = 2'b01;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.MemReady;
          bus.NextPC    = bus.MemReady;
          state_d       = bus.MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          bus.ALUSrcA   = 2'b01;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          case (bus.Op)
            2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: begin
              bus.Undef = 1'b1;
              state_d   = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          bus.ALUSrcB = 2'b01;
          state_d     = bus.Funct[0] ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          bus.AdrSrc = 1'b1;
          state_d    = bus.MemReady ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegW      = 1'b1;
          state_d       = S_FETCH;
        end
        S_MEMWR: begin
          bus.AdrSrc = 1'b1;
          bus.MemW   = 1'b1;
          state_d    = bus.MemReady ? S_FETCH : S_MEMWR;
        end
        S_EXECUTER: begin
          bus.ALUOp = 1'b1;
          state_d   = S_ALUWB;
        end
        S_EXECUTEI: begin
          bus.ALUSrcB = 2'b01;
          bus.ALUOp   = 1'b1;
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          bus.RegW = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          bus.ALUSrcA   = 2'b10;
          bus.ALUSrcB   = 2'b01;
          bus.ResultSrc = 2'b10;
          bus.Branch    = 1'b1;
          state_d       = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef MAIN_FSM_INSTR_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  // An instruction retires on the edge leaving its last state; undefined
  // opcodes never reach one of these, so they are not counted.
  always_comb begin
    retire = 1'b0;
    if (reset) begin
      case (state_q)
        S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
        S_MEMWR:                    retire = bus.MemReady;
        default:                    retire = 1'b0;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!reset)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 1'b1;
  end

  // Output forced to zero during reset along with every other output.
  always_comb begin
    InstrCount = reset ? cnt_q : '0;
  end
`endif

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Scoreboard bench for main_ctrl_fsm. The driver expands each instruction
// into its expected per-cycle control words and queues them; the monitor
// pops one entry per cycle and compares against the DUT.
module tb_main_ctrl_fsm;
  localparam int TB_CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_ctrl_fsm_if bus();

`ifdef MAIN_FSM_INSTR_CNT_EN
  logic [TB_CNT_W-1:0] instr_count;
`endif

  main_ctrl_fsm #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MAIN_FSM_INSTR_CNT_EN
    ,
    .InstrCount (instr_count)
`endif
  );

  typedef struct {
    logic [13:0] vec;
    int unsigned cnt;
    string       tag;
  } exp_t;

  typedef struct {
    logic [13:0] vec;
    logic        mr;
    logic [1:0]  op;
    logic [5:0]  funct;
    string       tag;
  } cyc_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned retired = 0;

  // Control word: {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,Undef}
  function automatic logic [13:0] mk(input logic irw, input logic npc, input logic adr,
                                     input logic [1:0] asa, input logic [1:0] asb,
                                     input logic [1:0] rs, input logic aluop,
                                     input logic regw, input logic memw,
                                     input logic br, input logic und);
    return {irw, npc, adr, asa, asb, rs, aluop, regw, memw, br, und};
  endfunction

  function automatic cyc_t cy(input logic [13:0] vec, input logic mr, input bit sampled,
                              input logic [1:0] op, input logic [5:0] funct, input string tag);
    cyc_t c;
    c.vec   = vec;
    c.mr    = mr;
    c.op    = sampled ? op    : 2'($urandom_range(0, 3));
    c.funct = sampled ? funct : 6'($urandom_range(0, 63));
    c.tag   = tag;
    return c;
  endfunction

  task automatic drive(input cyc_t c);
    exp_t e;
    reset        = 1'b1;
    bus.MemReady = c.mr;
    bus.Op       = c.op;
    bus.Funct    = c.funct;
    e.vec = c.vec;
    e.cnt = retired;
    e.tag = c.tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input logic [1:0] op);
    exp_t e;
    reset        = 1'b0;
    bus.MemReady = 1'($urandom_range(0, 1));
    bus.Op       = op;
    bus.Funct    = 6'($urandom_range(0, 63));
    e.vec = '0;
    e.cnt = 0;
    e.tag = "reset";
    sb_q.push_back(e);
    retired = 0;
    @(posedge clk);
    #1;
  endtask

  // One instruction: fw fetch stalls, mw memory stalls; optionally a reset
  // pulse replaces one of its cycles and aborts it.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int fw, input int mw, input bit do_abort);
    cyc_t plan[$];
    int   abort_at;
    logic r;
    for (int i = 0; i < fw; i++)
      plan.push_back(cy(mk(0,0,0,2'b01,2'b10,2'b10,0,0,0,0,0), 1'b0, 0, op, funct, "fetch_wait"));
    plan.push_back(cy(mk(1,1,0,2'b01,2'b10,2'b10,0,0,0,0,0), 1'b1, 0, op, funct, "fetch"));
    r = 1'($urandom_range(0, 1));
    plan.push_back(cy(mk(0,0,0,2'b01,2'b10,2'b10,0,0,0,0,(op == 2'b11)), r, 1, op, funct, "decode"));
    case (op)
      2'b00: begin
        r = 1'($urandom_range(0, 1));
        if (funct[5]) plan.push_back(cy(mk(0,0,0,2'b00,2'b01,2'b00,1,0,0,0,0), r, 0, op, funct, "exec_imm"));
        else          plan.push_back(cy(mk(0,0,0,2'b00,2'b00,2'b00,1,0,0,0,0), r, 0, op, funct, "exec_reg"));
        r = 1'($urandom_range(0, 1));
        plan.push_back(cy(mk(0,0,0,2'b00,2'b00,2'b00,0,1,0,0,0), r, 0, op, funct, "alu_wb"));
      end
      2'b01: begin
        r = 1'($urandom_range(0, 1));
        plan.push_back(cy(mk(0,0,0,2'b00,2'b01,2'b00,0,0,0,0,0), r, 1, op, funct, "mem_adr"));
        if (funct[0]) begin
          for (int i = 0; i < mw; i++)
            plan.push_back(cy(mk(0,0,1,2'b00,2'b00,2'b00,0,0,0,0,0), 1'b0, 0, op, funct, "mem_rd_wait"));
          plan.push_back(cy(mk(0,0,1,2'b00,2'b00,2'b00,0,0,0,0,0), 1'b1, 0, op, funct, "mem_rd"));
          r = 1'($urandom_range(0, 1));
          plan.push_back(cy(mk(0,0,0,2'b00,2'b00,2'b01,0,1,0,0,0), r, 0, op, funct, "mem_wb"));
        end else begin
          for (int i = 0; i < mw; i++)
            plan.push_back(cy(mk(0,0,1,2'b00,2'b00,2'b00,0,0,1,0,0), 1'b0, 0, op, funct, "mem_wr_wait"));
          plan.push_back(cy(mk(0,0,1,2'b00,2'b00,2'b00,0,0,1,0,0), 1'b1, 0, op, funct, "mem_wr"));
        end
      end
      2'b10: begin
        r = 1'($urandom_range(0, 1));
        plan.push_back(cy(mk(0,0,0,2'b10,2'b01,2'b10,0,0,0,1,0), r, 0, op, funct, "branch"));
      end
      default: ;
    endcase
    abort_at = do_abort ? $urandom_range(0, plan.size() - 1) : -1;
    for (int i = 0; i < plan.size(); i++) begin
      if (i == abort_at) begin
        reset_cycle(2'($urandom_range(0, 3)));
        return;
      end
      drive(plan[i]);
    end
    if (op != 2'b11) retired++;
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [13:0] got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
             bus.ALUOp, bus.RegW, bus.MemW, bus.Branch, bus.Undef};
      n_cmp++;
      if (got !== e.vec) begin
        n_bad++;
        $display("FAIL %s @%0t: controls got %014b expected %014b", e.tag, $time, got, e.vec);
      end
`ifdef MAIN_FSM_INSTR_CNT_EN
      n_cmp++;
      if (instr_count !== TB_CNT_W'(e.cnt)) begin
        n_bad++;
        $display("FAIL count_%s @%0t: InstrCount got %0d expected %0d", e.tag, $time,
                 instr_count, TB_CNT_W'(e.cnt));
      end
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.Op       = 2'b00;
    bus.Funct    = 6'b0;
    bus.MemReady = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) reset_cycle(2'b00);

    run_instr(2'b00, 6'b001000, 0, 0, 0);    // ADD reg
    run_instr(2'b00, 6'b101000, 1, 0, 0);    // ADD imm, one fetch stall
    run_instr(2'b01, 6'b011001, 0, 2, 0);    // LDR, two read stalls
    run_instr(2'b01, 6'b011000, 0, 1, 0);    // STR, one write stall
    run_instr(2'b11, 6'b000000, 0, 0, 0);    // undefined
    run_instr(2'b10, 6'b000000, 0, 0, 0);    // B
    run_instr(2'b01, 6'b000001, 0, 3, 1);    // LDR aborted by reset

    reset_cycle(2'b00);
    for (int i = 0; i < 17; i++) run_instr(2'b10, 6'($urandom_range(0, 63)), 0, 0, 0);

    for (int n = 0; n < 300; n++)
      run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 19) == 0));

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: scoreboard entries left %0d expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
